// File: rtl/gpio_filter_sched_pkg.sv
// Shared constants, index-width helper and event record for the GPIO filter scheduler.
package gpio_filter_sched_pkg;

  localparam int DEF_DIV  = 3;
  localparam int CH_MAX_W = 5;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [CH_MAX_W-1:0] ch;
    logic                level;
  } evt_t;

endpackage

// File: rtl/gpio_filter_sched_rr_arbiter.sv
// Combinational round-robin grant: first request strictly after last_gnt, wrapping.
module gpio_filter_sched_rr_arbiter
  import gpio_filter_sched_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic [NCH-1:0]         req,
  input  logic [ch_w(NCH)-1:0]   last_gnt,
  output logic [NCH-1:0]         gnt_oh,
  output logic [ch_w(NCH)-1:0]   gnt_idx,
  output logic                   gnt_any
);

  localparam int IW = ch_w(NCH);
  localparam int PW = $clog2(2 * NCH);

  logic [2*NCH-1:0] req_dbl;

  assign req_dbl = {req, req};

  // Scan farthest-first so the nearest request after last_gnt is the final write.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      if (req_dbl[PW'(int'(last_gnt) + k)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(last_gnt) + k) % NCH);
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/gpio_filter_sched.sv
// Per-channel sample-strobe generator and change-event scheduler for a GPIO filter bank.
module gpio_filter_sched
  import gpio_filter_sched_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int DIVW    = 8,
  parameter int DEF_DIV = gpio_filter_sched_pkg::DEF_DIV
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NCH-1:0]          ch_en,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [DIVW-1:0]         cfg_div,
  input  logic [NCH-1:0]          fin,
  output logic [NCH-1:0]          ena,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(NCH)-1:0]  evt_ch,
  output logic                    evt_level,
  output logic [NCH-1:0]          ovf,
  input  logic [NCH-1:0]          ovf_clr
);

  localparam int IW = ch_w(NCH);

  logic [NCH-1:0] pending_vec;
  logic [NCH-1:0] last_vec;
  logic [NCH-1:0] gnt_oh;
  logic [IW-1:0]  gnt_idx;
  logic           gnt_any;
  logic           slot_free;
  logic [IW-1:0]  rr_ptr_reg;
  logic           evt_valid_reg;
  evt_t           evt_reg;

  assign slot_free = !evt_valid_reg || evt_ready;

  gpio_filter_sched_rr_arbiter #(.NCH(NCH)) u_arb (
    .req      (pending_vec),
    .last_gnt (rr_ptr_reg),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DIVW-1:0] div_reg;
      logic [DIVW-1:0] cnt_reg;
      logic            ena_reg;
      logic            last_reg;
      logic            pending_reg;
      logic            ovf_reg;
      logic            cfg_hit;
      logic            change;
      logic            granted;

      assign cfg_hit = cfg_we && (cfg_ch == IW'(gi));
      assign change  = ch_en[gi] && (fin[gi] != last_reg);
      assign granted = slot_free && gnt_oh[gi];

      // last follows fin unconditionally: when enabled it only differs on a change,
      // when disabled it tracks silently so re-enabling raises no event.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          div_reg     <= DIVW'(DEF_DIV);
          cnt_reg     <= '0;
          ena_reg     <= 1'b0;
          last_reg    <= 1'b1;
          pending_reg <= 1'b0;
          ovf_reg     <= 1'b0;
        end else begin
          if (cfg_hit) begin
            div_reg <= cfg_div;
            cnt_reg <= '0;
            ena_reg <= 1'b0;
          end else if (!ch_en[gi]) begin
            cnt_reg <= '0;
            ena_reg <= 1'b0;
          end else if (cnt_reg == div_reg) begin
            cnt_reg <= '0;
            ena_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            ena_reg <= 1'b0;
          end

          last_reg <= fin[gi];

          // A new change beats a same-cycle grant, so the newer level is re-posted.
          if (change) pending_reg <= 1'b1;
          else if (granted) pending_reg <= 1'b0;

          if (change && pending_reg && !granted) ovf_reg <= 1'b1;
          else if (ovf_clr[gi]) ovf_reg <= 1'b0;
        end
      end

      assign ena[gi]         = ena_reg;
      assign ovf[gi]         = ovf_reg;
      assign pending_vec[gi] = pending_reg;
      assign last_vec[gi]    = last_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid_reg <= 1'b0;
      evt_reg       <= '0;
      rr_ptr_reg    <= IW'(NCH - 1);
    end else if (slot_free) begin
      if (gnt_any) begin
        evt_valid_reg <= 1'b1;
        evt_reg.ch    <= CH_MAX_W'(gnt_idx);
        evt_reg.level <= last_vec[gnt_idx];
        rr_ptr_reg    <= gnt_idx;
      end else begin
        evt_valid_reg <= 1'b0;
      end
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_ch    = IW'(evt_reg.ch);
  assign evt_level = evt_reg.level;

endmodule
